seg_scan_mux: RTL and testbench

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_scan_mux.sv | 122 ++++++++++++
 tb/tb_seg_scan_mux.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment hex display for a selectable debug channel.
// A snapshot of one channel is latched once per frame and scanned out digit by digit.
module seg_scan_mux #(
  parameter int NUM_CH   = 4,
  parameter int DW       = 32,
  parameter int SCAN_DIV = 20000,
  localparam int ND      = DW / 4,
  localparam int SW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH*DW-1:0] ch_data,
  input  logic [SW-1:0]        ch_sel,
  input  logic                 freeze,
  input  logic                 blank_lz,
  output logic [7:0]           o_seg,
  output logic [ND-1:0]        o_sel,
  output logic [SW-1:0]        cur_ch
);

  localparam int PW   = $clog2(SCAN_DIV);
  localparam int DIGW = (ND > 1) ? $clog2(ND) : 1;

  logic [PW-1:0]   presc_q, presc_d;
  logic [DIGW-1:0] dig_q, dig_d;
  logic [DW-1:0]   snap_q, snap_d;
  logic [SW-1:0]   cur_ch_q, cur_ch_d;
  logic [7:0]      seg_q, seg_d;
  logic [ND-1:0]   sel_q, sel_d;
  logic            tick;
  logic            frame;
  logic [DW-1:0]   pick_data;
  logic [SW-1:0]   pick_ch;
  logic [3:0]      nib;
  int              msnz;

  // Segment pattern g..a, active-low, without the dp bit.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    tick    = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
    frame   = tick && (dig_q == DIGW'(ND - 1));
    dig_d   = dig_q;
    if (tick) dig_d = frame ? '0 : dig_q + DIGW'(1);

    // Unmatched (out-of-range) selects fall back to channel 0.
    pick_data = ch_data[DW-1:0];
    pick_ch   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(ch_sel) == k) begin
        pick_data = ch_data[k*DW +: DW];
        pick_ch   = SW'(k);
      end
    end

    snap_d   = snap_q;
    cur_ch_d = cur_ch_q;
    if (frame && !freeze) begin
      snap_d   = pick_data;
      cur_ch_d = pick_ch;
    end

    // Outputs are built from snap_d so the first digit of a new frame already shows the new snapshot.
    nib  = snap_d[3:0];
    msnz = 0;
    for (int i = 0; i < ND; i++) begin
      if (int'(dig_d) == i) nib = snap_d[4*i +: 4];
      if (snap_d[4*i +: 4] != 4'h0) msnz = i;
    end

    sel_d = sel_q;
    seg_d = seg_q;
    if (tick) begin
      for (int i = 0; i < ND; i++) sel_d[i] = (int'(dig_d) != i);
      seg_d[7]   = !(freeze && (dig_d == '0));
      seg_d[6:0] = (blank_lz && (int'(dig_d) > msnz)) ? 7'h7F : hex7(nib);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q  <= '0;
      dig_q    <= '0;
      snap_q   <= '0;
      cur_ch_q <= '0;
      seg_q    <= 8'hFF;
      sel_q    <= '1;
    end else begin
      presc_q  <= presc_d;
      dig_q    <= dig_d;
      snap_q   <= snap_d;
      cur_ch_q <= cur_ch_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
    end
  end

  assign o_seg  = seg_q;
  assign o_sel  = sel_q;
  assign cur_ch = cur_ch_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: arithmetic display model checked every cycle, plus
// hand-computed digit patterns for scanning, selection, blanking, freeze and reset.
module tb_seg_scan_mux;

  localparam int NUM_CH   = 4;
  localparam int DW       = 32;
  localparam int SCAN_DIV = 4;
  localparam int ND       = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] ch_data;
  logic [1:0]   ch_sel;
  logic         freeze;
  logic         blank_lz;
  logic [7:0]   o_seg;
  logic [7:0]   o_sel;
  logic [1:0]   cur_ch;

  int vectors = 0;
  int miscompares = 0;

  seg_scan_mux #(.NUM_CH(NUM_CH), .DW(DW), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_sel(ch_sel),
    .freeze(freeze), .blank_lz(blank_lz),
    .o_seg(o_seg), .o_sel(o_sel), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  logic [7:0] hex_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: edge n after reset is a tick when n is a multiple of SCAN_DIV;
  // the displayed digit is the tick count modulo ND, and digit 0 starts a frame.
  logic        m_valid = 1'b0;
  int          m_n;
  logic [31:0] m_snap;
  logic [1:0]  m_cur;
  logic [7:0]  m_seg, m_sel;

  function automatic logic [7:0] m_seg_f(logic [31:0] s, int d, logic bl, logic fr);
    logic [7:0]  v;
    logic [31:0] upper;
    upper = s >> (4 * d);
    v = hex_lut[upper[3:0]];
    if (bl && d > 0 && upper == 0) v = 8'hFF;
    v[7] = !(fr && d == 0);
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 1'b1;
      m_n = 0; m_snap = 0; m_cur = 0; m_seg = 8'hFF; m_sel = 8'hFF;
    end else begin
      int d;
      m_n++;
      if (m_n % SCAN_DIV == 0) begin
        d = (m_n / SCAN_DIV) % ND;
        if (d == 0 && !freeze) begin
          m_snap = ch_data[int'(ch_sel)*32 +: 32];
          m_cur  = ch_sel;
        end
        m_sel = ~(8'd1 << d);
        m_seg = m_seg_f(m_snap, d, blank_lz, freeze);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_seg", {24'd0, o_seg}, {24'd0, m_seg});
      check("model_sel", {24'd0, o_sel}, {24'd0, m_sel});
      check("model_cur", {30'd0, cur_ch}, {30'd0, m_cur});
    end
  end

  // Wait for a fresh arrival of the slot for digit idx.
  task automatic wait_slot(input int idx);
    int n;
    logic [7:0] tgt;
    tgt = ~(8'd1 << idx);
    n = 0;
    while (o_sel == tgt && n < 100) begin @(negedge clk); n++; end
    while (o_sel != tgt && n < 200) begin @(negedge clk); n++; end
    if (o_sel != tgt) check("slot_timeout", {24'd0, o_sel}, {24'd0, tgt});
  endtask

  task automatic check_digit(input string nm, input int idx, input logic [7:0] exp);
    wait_slot(idx);
    check(nm, {24'd0, o_seg}, {24'd0, exp});
  endtask

  logic [7:0] walk   [8] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
  logic [7:0] pat_ch2[8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

  initial begin
    int n;
    ch_data  = {32'hDEADBEEF, 32'h12345678, 32'h000000A0, 32'h00000000};
    ch_sel   = 2'd0;
    freeze   = 1'b0;
    blank_lz = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_seg", {24'd0, o_seg}, 32'hFF);
    check("reset_sel", {24'd0, o_sel}, 32'hFF);
    check("reset_cur", {30'd0, cur_ch}, 32'd0);
    rst = 1'b1;

    // Scan walk after reset: one digit step every SCAN_DIV cycles.
    for (int s = 0; s < 8; s++) begin
      repeat (SCAN_DIV) @(negedge clk);
      check("walk_sel", {24'd0, o_sel}, {24'd0, walk[s]});
      check("walk_seg", {24'd0, o_seg}, 32'hC0);
    end

    // Channel 2 appears at the next frame boundary.
    ch_sel = 2'd2;
    for (int i = 0; i < 8; i++) check_digit("ch2_digit", i, pat_ch2[i]);
    check("ch2_cur", {30'd0, cur_ch}, 32'd2);

    // Leading-zero blanking on 0x000000A0.
    blank_lz = 1'b1;
    ch_sel   = 2'd1;
    check_digit("blank_d0", 0, 8'hC0);
    check("blank_cur", {30'd0, cur_ch}, 32'd1);
    check_digit("blank_d1", 1, 8'h88);
    for (int i = 2; i < 8; i++) check_digit("blank_hi", i, 8'hFF);

    // Freeze holds the snapshot across three frames; dp lit on digit 0 only.
    freeze = 1'b1;
    ch_sel = 2'd3;
    ch_data[63:32] = 32'h00000005;
    for (int f = 0; f < 3; f++) begin
      check_digit("frz_d0", 0, 8'h40);
      check("frz_cur", {30'd0, cur_ch}, 32'd1);
      check_digit("frz_d1", 1, 8'h88);
      check_digit("frz_d2", 2, 8'hFF);
    end
    freeze = 1'b0;
    check_digit("unfrz_d0", 0, 8'h8E);
    check("unfrz_cur", {30'd0, cur_ch}, 32'd3);

    // Mid-frame select change has no effect until the frame boundary.
    wait_slot(2);
    ch_sel = 2'd2;
    check_digit("mid_d3", 3, 8'h83);
    check("mid_cur", {30'd0, cur_ch}, 32'd3);
    check_digit("mid_d7", 7, 8'hA1);
    check_digit("mid_new_d0", 0, 8'h80);
    check("mid_new_cur", {30'd0, cur_ch}, 32'd2);

    // Short asynchronous reset pulse mid-frame.
    wait_slot(1);
    #2 rst = 1'b0;
    #1;
    check("rst_pulse_seg", {24'd0, o_seg}, 32'hFF);
    check("rst_pulse_sel", {24'd0, o_sel}, 32'hFF);
    check("rst_pulse_cur", {30'd0, cur_ch}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (o_sel != 8'hFD && n < 50) begin @(negedge clk); n++; end
    check("restart_latency", n, SCAN_DIV);
    check("restart_seg", {24'd0, o_seg}, 32'hFF);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
